// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache: zero-latency hits, full-line
// burst refill on a miss, and a flush that invalidates every line.
module icache_dm #(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_addr_ok,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,
    input  logic        flush,
    output logic        creq_valid,
    output logic [63:0] creq_addr,
    output logic [7:0]  creq_len,
    input  logic        cresp_ready,
    input  logic        cresp_last,
    input  logic [63:0] cresp_data
);

    localparam int WB   = $clog2(LINE_WORDS);
    localparam int OFS  = 3 + WB;
    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = 64 - OFS - IDX;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t             state;
    logic [SETS-1:0]    valid;
    logic [TAGW-1:0]    tags [SETS];
    logic [63:0]        data [SETS*LINE_WORDS];
    logic [63-OFS:0]    fill_line;
    logic [WB-1:0]      count;
    logic               flush_pending;

    logic [IDX-1:0]     req_idx;
    logic [WB-1:0]      req_word;
    logic [TAGW-1:0]    req_tag;
    logic [IDX-1:0]     fill_idx;
    logic [TAGW-1:0]    fill_tag;
    logic [63:0]        hit_word;
    logic               hit;
    logic               unused_addr_bits;

    assign req_word = ireq_addr[OFS-1:3];
    assign req_idx  = ireq_addr[OFS+IDX-1:OFS];
    assign req_tag  = ireq_addr[63:OFS+IDX];
    assign fill_idx = fill_line[IDX-1:0];
    assign fill_tag = fill_line[63-OFS:IDX];
    assign unused_addr_bits = ^ireq_addr[1:0];

    assign hit_word = data[{req_idx, req_word}];
    assign hit = (state == IDLE) && ireq_valid && valid[req_idx]
                 && (tags[req_idx] == req_tag) && !flush;

    assign iresp_addr_ok = hit;
    assign iresp_data_ok = hit;
    assign iresp_data    = hit ? (ireq_addr[2] ? hit_word[63:32] : hit_word[31:0]) : 32'd0;
    assign creq_valid    = (state == REFILL);
    assign creq_addr     = {fill_line, {OFS{1'b0}}};
    assign creq_len      = 8'(LINE_WORDS - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            valid         <= '0;
            fill_line     <= '0;
            count         <= '0;
            flush_pending <= 1'b0;
        end else if (state == IDLE) begin
            if (flush) begin
                valid <= '0;
            end else if (ireq_valid && !hit) begin
                state     <= REFILL;
                fill_line <= ireq_addr[63:OFS];
                count     <= '0;
            end
        end else begin
            // The burst always completes; a flush only marks the fill line as stale.
            if (flush) begin
                valid         <= '0;
                flush_pending <= 1'b1;
            end
            if (cresp_ready) begin
                count <= count + WB'(1);
                if (cresp_last) begin
                    // NOTE: this non-blocking write lands after the flush clear above, so it wins for this line.
                    valid[fill_idx] <= !(flush_pending || flush);
                    flush_pending   <= 1'b0;
                    state           <= IDLE;
                end
            end
        end
    end

    // NOTE: line data and tags carry no reset; the valid bits alone make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (state == REFILL && cresp_ready) begin
            data[{fill_idx, count}] <= cresp_data;
            if (cresp_last)
                tags[fill_idx] <= fill_tag;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed vector table, flush/reset
// corner sequences and a randomized run against a line-level cache model.
module tb_icache_dm;

    localparam int SETS       = 16;
    localparam int LINE_WORDS = 4;
    localparam int LINE_BYTES = LINE_WORDS * 8;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        flush;
    logic        creq_valid;
    logic [63:0] creq_addr;
    logic [7:0]  creq_len;
    logic        cresp_ready;
    logic        cresp_last;
    logic [63:0] cresp_data;

    icache_dm #(.SETS(SETS), .LINE_WORDS(LINE_WORDS)) dut (
        .clk           (clk),
        .reset         (reset),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_addr_ok (iresp_addr_ok),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .flush         (flush),
        .creq_valid    (creq_valid),
        .creq_addr     (creq_addr),
        .creq_len      (creq_len),
        .cresp_ready   (cresp_ready),
        .cresp_last    (cresp_last),
        .cresp_data    (cresp_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Backing memory: every 64-bit word is a fixed function of its address.
    function automatic logic [63:0] mem64(input logic [63:0] a);
        return {a[31:0] + 32'h1000_0004, a[31:0] ^ 32'h5A5A_5A5A};
    endfunction

    function automatic logic [31:0] mem_insn(input logic [63:0] a);
        logic [63:0] w;
        w = mem64({a[63:3], 3'b000});
        return a[2] ? w[63:32] : w[31:0];
    endfunction

    // Cache model: which line address each set currently holds, if any.
    bit          mval  [SETS];
    logic [63:0] mline [SETS];

    function automatic logic [63:0] line_of(input logic [63:0] a);
        return a - (a % LINE_BYTES);
    endfunction

    function automatic int idx_of(input logic [63:0] a);
        return int'((a / LINE_BYTES) % SETS);
    endfunction

    function automatic bit model_hit(input logic [63:0] a);
        return mval[idx_of(a)] && (mline[idx_of(a)] == line_of(a));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < SETS; i++) mval[i] = 1'b0;
    endtask

    // Serve one burst for the line; called at the negedge of the first REFILL cycle.
    task automatic refill(input logic [63:0] line, input int flush_beat, input int gap);
        bit flushed = 1'b0;
        for (int b = 0; b < LINE_WORDS; b++) begin
            for (int g = 0; g < gap; g++) begin
                cresp_ready = 1'b0;
                #1;
                check("gap_creq_valid", creq_valid, 1'b1);
                check("gap_addr_ok", iresp_addr_ok, 1'b0);
                @(negedge clk);
            end
            cresp_ready = 1'b1;
            cresp_last  = (b == LINE_WORDS - 1);
            cresp_data  = mem64(line + 64'(8 * b));
            flush       = (b == flush_beat);
            #1;
            check("beat_creq_valid", creq_valid, 1'b1);
            check("beat_creq_addr", creq_addr, line);
            check("beat_creq_len", creq_len, 64'(LINE_WORDS - 1));
            check("beat_data_ok", iresp_data_ok, 1'b0);
            if (flush) begin
                flushed = 1'b1;
                model_clear();
            end
            @(negedge clk);
        end
        cresp_ready = 1'b0;
        cresp_last  = 1'b0;
        flush       = 1'b0;
        mval[idx_of(line)]  = !flushed;
        mline[idx_of(line)] = line;
    endtask

    // Present one fetch and hold it until it hits, serving every refill it causes.
    task automatic fetch(input logic [63:0] addr, input bit exp_hit, input logic [31:0] exp_data,
                         input int flush_beat, input int gap, output int refills);
        bit want_hit;
        refills    = 0;
        want_hit   = exp_hit;
        ireq_valid = 1'b1;
        ireq_addr  = addr;
        for (int attempt = 0; attempt < 4; attempt++) begin
            #1;
            if (attempt > 0) want_hit = model_hit(addr);
            check("addr_ok", iresp_addr_ok, want_hit);
            check("data_ok", iresp_data_ok, want_hit);
            check("idle_creq_valid", creq_valid, 1'b0);
            if (want_hit) begin
                check("hit_data", iresp_data, exp_data);
                break;
            end
            @(negedge clk);
            refills++;
            refill(line_of(addr), (attempt == 0) ? flush_beat : -1, gap);
        end
        @(negedge clk);
        ireq_valid = 1'b0;
    endtask

    typedef struct {
        logic [63:0] addr;
        bit          hit;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int refills;
        logic [63:0] a;

        reset       = 1'b1;
        ireq_valid  = 1'b0;
        ireq_addr   = '0;
        flush       = 1'b0;
        cresp_ready = 1'b0;
        cresp_last  = 1'b0;
        cresp_data  = '0;
        model_clear();
        for (int i = 0; i < SETS; i++) mline[i] = '0;

        #2;
        check("rst_addr_ok", iresp_addr_ok, 1'b0);
        check("rst_data_ok", iresp_data_ok, 1'b0);
        check("rst_data", iresp_data, 32'd0);
        check("rst_creq_valid", creq_valid, 1'b0);
        check("rst_creq_addr", creq_addr, 64'd0);
        check("rst_creq_len", creq_len, 64'(LINE_WORDS - 1));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Cold miss, same-line hits, then conflict eviction on set 0.
        vecs[0] = '{64'h8000_0000, 1'b0, 32'hDA5A_5A5A};
        vecs[1] = '{64'h8000_0004, 1'b1, 32'h9000_0004};
        vecs[2] = '{64'h8000_0018, 1'b1, 32'hDA5A_5A42};
        vecs[3] = '{64'h8000_001C, 1'b1, 32'h9000_001C};
        vecs[4] = '{64'h8000_0200, 1'b0, 32'hDA5A_585A};
        vecs[5] = '{64'h8000_0000, 1'b0, 32'hDA5A_5A5A};
        vecs[6] = '{64'h8000_0004, 1'b1, 32'h9000_0004};
        for (int i = 0; i < 7; i++) begin
            fetch(vecs[i].addr, vecs[i].hit, vecs[i].data, -1, 1, refills);
            check("vec_refills", refills, vecs[i].hit ? 0 : 1);
        end

        // Flush in IDLE: no ok in the flush cycle, no refill, then a fresh miss.
        fetch(64'h8000_0020, 1'b0, mem_insn(64'h8000_0020), -1, 0, refills);
        fetch(64'h8000_0024, 1'b1, mem_insn(64'h8000_0024), -1, 0, refills);
        ireq_valid = 1'b1;
        ireq_addr  = 64'h8000_0020;
        flush      = 1'b1;
        #1;
        check("flush_addr_ok", iresp_addr_ok, 1'b0);
        check("flush_data_ok", iresp_data_ok, 1'b0);
        @(negedge clk);
        flush      = 1'b0;
        ireq_valid = 1'b0;
        model_clear();
        #1;
        check("flush_no_refill", creq_valid, 1'b0);
        @(negedge clk);
        fetch(64'h8000_0020, 1'b0, mem_insn(64'h8000_0020), -1, 0, refills);
        check("flush_idle_refills", refills, 1);

        // Flush on beat 2 of a fill: burst completes, retry refills again, then hits.
        fetch(64'h8000_0040, 1'b0, mem_insn(64'h8000_0040), 2, 0, refills);
        check("flush_mid_refills", refills, 2);
        fetch(64'h8000_0048, 1'b1, mem_insn(64'h8000_0048), -1, 0, refills);
        check("flush_mid_hit_refills", refills, 0);

        // Randomized fetches and occasional idle flushes against the model.
        for (int n = 0; n < 80; n++) begin
            a = 64'h8000_0000 + 64'($urandom_range(0, 255) << 2);
            if ($urandom_range(0, 9) == 0) begin
                ireq_valid = 1'($urandom_range(0, 1));
                ireq_addr  = a;
                flush      = 1'b1;
                #1;
                check("rnd_flush_addr_ok", iresp_addr_ok, 1'b0);
                @(negedge clk);
                flush      = 1'b0;
                ireq_valid = 1'b0;
                model_clear();
                #1;
                check("rnd_flush_no_refill", creq_valid, 1'b0);
                @(negedge clk);
            end
            fetch(a, model_hit(a), mem_insn(a), -1, int'($urandom_range(0, 2)), refills);
        end

        // Reset after beat 1 of a refill: outputs drop at once, cache comes back empty.
        ireq_valid = 1'b1;
        ireq_addr  = 64'h8000_1080;
        #1;
        check("rm_first_miss", iresp_addr_ok, 1'b0);
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            cresp_ready = 1'b1;
            cresp_data  = mem64(64'h8000_1080 + 64'(8 * b));
            @(negedge clk);
        end
        cresp_ready = 1'b0;
        #1;
        check("rm_pre_creq_valid", creq_valid, 1'b1);
        reset = 1'b1;
        #1;
        check("rm_creq_valid", creq_valid, 1'b0);
        check("rm_addr_ok", iresp_addr_ok, 1'b0);
        check("rm_data_ok", iresp_data_ok, 1'b0);
        @(negedge clk);
        reset      = 1'b0;
        ireq_valid = 1'b0;
        model_clear();
        @(negedge clk);
        fetch(64'h8000_0000, 1'b0, 32'hDA5A_5A5A, -1, 1, refills);
        check("rm_after_refills", refills, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
